forwarding_scoreboard: RTL and testbench
========================================

FORWARDING_SCOREBOARD -- requirements
Module: forwarding_scoreboard

Interface
REQ-001 SHALL have parameter REG_ADDRS_BITS, default `REG_ADDRS_BITS (5), register address width.
REQ-002 SHALL have parameter NUM_SRC, default 2, number of source operands per instruction.
REQ-003 SHALL have parameter LAT_BITS, default 3, multicycle-unit latency field width.
REQ-004 SHALL have port i_clock  in  1  single clock, rising edge.
REQ-005 SHALL have port i_reset  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports i_ex_mem_RegWrite / i_mem_wb_RegWrite  in  1  stage will write a register.
REQ-007 SHALL have ports i_ex_mem_rd / i_mem_wb_rd  in  REG_ADDRS_BITS  stage destination register.
REQ-008 SHALL have port i_id_ex_src  in  NUM_SRC*REG_ADDRS_BITS  ID/EX sources, source k at bits [k*RB +: RB].
REQ-009 SHALL have port i_if_id_src  in  NUM_SRC*REG_ADDRS_BITS  IF/ID sources, same packing.
REQ-010 SHALL have ports i_id_ex_MemRead  in 1, i_id_ex_rt  in REG_ADDRS_BITS  load in EX and its destination.
REQ-011 SHALL have ports i_mc_issue  in 1, i_mc_rd  in REG_ADDRS_BITS, i_mc_latency  in LAT_BITS  multicycle op issue.
REQ-012 SHALL have port i_if_id_mc_req  in 1  IF/ID instruction is a multicycle op.
REQ-013 SHALL have port o_foward  out  2*NUM_SRC  per-source select, source k at [2k +: 2].
REQ-014 SHALL have ports o_stall out 1, o_mc_busy out 1, o_mc_wb_valid out 1, o_mc_wb_rd out REG_ADDRS_BITS, o_mc_overrun out 1.

Function
REQ-015 SHALL encode o_foward per source: 00 regfile, 10 EX/MEM, 01 MEM/WB, 11 multicycle result.
REQ-016 SHALL select 10 when i_ex_mem_RegWrite, i_ex_mem_rd!=0, rd==source; else 01 under same test on MEM/WB; else 11 when o_mc_wb_valid, o_mc_wb_rd!=0, rd==source; else 00.
REQ-017 SHALL compute o_foward combinationally, zero-cycle latency.
REQ-018 SHALL implement FSM states IDLE, BUSY, DONE for one multicycle slot.
REQ-019 SHALL accept issue when i_mc_issue in IDLE or DONE: capture rd, load counter with max(latency,1)-1, go BUSY.
REQ-020 SHALL decrement counter each cycle in BUSY; at counter==0 go DONE next edge.
REQ-021 SHALL in DONE assert o_mc_wb_valid=1, o_mc_wb_rd=captured rd for exactly one cycle; go IDLE unless new issue accepted (then BUSY).
REQ-022 SHALL assert o_mc_busy=1 only in BUSY.
REQ-023 SHALL ignore i_mc_issue in BUSY and set sticky o_mc_overrun=1 until reset.
REQ-024 SHALL assert o_stall combinationally when (i_id_ex_MemRead, i_id_ex_rt!=0, rt equals any IF/ID source) or (BUSY, captured rd!=0, rd equals any IF/ID source) or (BUSY and i_if_id_mc_req).
REQ-025 SHALL treat register 0 as never hazardous and never forwarded.

Reset
REQ-026 SHALL on i_reset low, asynchronously: state IDLE, counter 0, captured rd 0, o_mc_overrun 0.
REQ-027 SHALL hold o_mc_busy=0, o_mc_wb_valid=0, o_mc_wb_rd=0 during and after reset; reset mid-BUSY SHALL produce no writeback pulse.

Structure
REQ-028 SHALL take REG_ADDRS_BITS, LAT_BITS defaults and forward-select codes (FWD_REG, FWD_EXMEM, FWD_MEMWB, FWD_MC) and FSM state codes from constants.vh.
REQ-029 SHALL place per-source compare/priority logic in sub-module fwd_select, instantiated NUM_SRC times via generate.

Verification
REQ-030 SHALL cover: EX/MEM rd=5 RegWrite, MEM/WB rd=5 RegWrite, src0=5 -> o_foward[1:0]=10; rd=0 both -> 00.
REQ-031 SHALL cover: i_id_ex_MemRead=1, rt=7, i_if_id_src src1=7 -> o_stall=1; rt=0 -> o_stall=0.
REQ-032 SHALL cover: issue rd=9 latency=4 -> o_mc_busy 4 cycles, o_mc_wb_valid on 5th cycle with rd=9, IF/ID src=9 stalls throughout BUSY, ID/EX src=9 in DONE -> 11.
REQ-033 SHALL cover: latency=0 and latency=1 -> both BUSY one cycle then DONE; issue in DONE -> back-to-back BUSY, no IDLE cycle.
REQ-034 SHALL cover: issue during BUSY -> ignored, o_mc_overrun=1 sticky; i_mc_req in BUSY -> o_stall=1.
REQ-035 SHALL cover: reset asserted mid-BUSY, asynchronous to clock -> outputs zero immediately, no o_mc_wb_valid after release.

Source files
------------

// File: rtl/forwarding_scoreboard_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : forwarding_scoreboard_pkg
//  Brief    : Shared constants and types for the forwarding scoreboard:
//             default widths, forward-select codes and the multicycle
//             slot state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package forwarding_scoreboard_pkg;

    // Default widths
    localparam int REG_ADDRS_BITS_DEF = 5;
    localparam int LAT_BITS_DEF       = 3;

    // Per-source operand select codes
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_MC    = 2'b11;

    // Multicycle slot states
    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

endpackage
`default_nettype wire

// File: rtl/forwarding_scoreboard_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : forwarding_scoreboard_if
//  Brief    : Pipeline hazard / forwarding bus between the pipeline control
//             (master) and the forwarding scoreboard (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface forwarding_scoreboard_if
    import forwarding_scoreboard_pkg::*;
#(
    parameter int REG_ADDRS_BITS = REG_ADDRS_BITS_DEF,
    parameter int NUM_SRC        = 2,
    parameter int LAT_BITS       = LAT_BITS_DEF
) ();

    logic                               i_ex_mem_RegWrite;
    logic                               i_mem_wb_RegWrite;
    logic [REG_ADDRS_BITS-1:0]          i_ex_mem_rd;
    logic [REG_ADDRS_BITS-1:0]          i_mem_wb_rd;
    logic [NUM_SRC*REG_ADDRS_BITS-1:0]  i_id_ex_src;
    logic [NUM_SRC*REG_ADDRS_BITS-1:0]  i_if_id_src;
    logic                               i_id_ex_MemRead;
    logic [REG_ADDRS_BITS-1:0]          i_id_ex_rt;
    logic                               i_mc_issue;
    logic [REG_ADDRS_BITS-1:0]          i_mc_rd;
    logic [LAT_BITS-1:0]                i_mc_latency;
    logic                               i_if_id_mc_req;

    logic [2*NUM_SRC-1:0]               o_foward;
    logic                               o_stall;
    logic                               o_mc_busy;
    logic                               o_mc_wb_valid;
    logic [REG_ADDRS_BITS-1:0]          o_mc_wb_rd;
    logic                               o_mc_overrun;

    // Scoreboard side
    modport slave (
        input  i_ex_mem_RegWrite, i_mem_wb_RegWrite, i_ex_mem_rd, i_mem_wb_rd,
        input  i_id_ex_src, i_if_id_src, i_id_ex_MemRead, i_id_ex_rt,
        input  i_mc_issue, i_mc_rd, i_mc_latency, i_if_id_mc_req,
        output o_foward, o_stall, o_mc_busy, o_mc_wb_valid, o_mc_wb_rd,
        output o_mc_overrun
    );

    // Pipeline control side
    modport master (
        output i_ex_mem_RegWrite, i_mem_wb_RegWrite, i_ex_mem_rd, i_mem_wb_rd,
        output i_id_ex_src, i_if_id_src, i_id_ex_MemRead, i_id_ex_rt,
        output i_mc_issue, i_mc_rd, i_mc_latency, i_if_id_mc_req,
        input  o_foward, o_stall, o_mc_busy, o_mc_wb_valid, o_mc_wb_rd,
        input  o_mc_overrun
    );

endinterface
`default_nettype wire

// File: rtl/forwarding_scoreboard_fwd_select.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fwd_select
//  Brief    : Operand forward select for one source register. Priority is
//             EX/MEM, then MEM/WB, then the multicycle writeback, else the
//             register file. Register 0 is never forwarded.
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_select
    import forwarding_scoreboard_pkg::*;
#(
    parameter int REG_ADDRS_BITS = REG_ADDRS_BITS_DEF
) (
    input  wire logic                      i_ex_mem_we,
    input  wire logic [REG_ADDRS_BITS-1:0] i_ex_mem_rd,
    input  wire logic                      i_mem_wb_we,
    input  wire logic [REG_ADDRS_BITS-1:0] i_mem_wb_rd,
    input  wire logic                      i_mc_valid,
    input  wire logic [REG_ADDRS_BITS-1:0] i_mc_rd,
    input  wire logic [REG_ADDRS_BITS-1:0] i_src,
    output logic      [1:0]                o_sel
);

    // Newest producer wins; a zero destination never matches
    always_comb begin
        o_sel = FWD_REG;
        if (i_ex_mem_we && (i_ex_mem_rd != '0) && (i_ex_mem_rd == i_src)) begin
            o_sel = FWD_EXMEM;
        end else if (i_mem_wb_we && (i_mem_wb_rd != '0) && (i_mem_wb_rd == i_src)) begin
            o_sel = FWD_MEMWB;
        end else if (i_mc_valid && (i_mc_rd != '0) && (i_mc_rd == i_src)) begin
            o_sel = FWD_MC;
        end
    end

endmodule
`default_nettype wire

// File: rtl/forwarding_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : forwarding_scoreboard
//  Brief    : Forwarding select, load-use / multicycle stall detection and a
//             single-slot multicycle unit tracker (IDLE -> BUSY -> DONE).
//  Revision : 1.0 - initial release
// ============================================================================
module forwarding_scoreboard
    import forwarding_scoreboard_pkg::*;
#(
    parameter int REG_ADDRS_BITS = REG_ADDRS_BITS_DEF,
    parameter int NUM_SRC        = 2,
    parameter int LAT_BITS       = LAT_BITS_DEF
) (
    input  wire logic               i_clock,
    input  wire logic               i_reset,
    forwarding_scoreboard_if.slave  bus
);

    mc_state_e                 state_q, state_d;
    logic [LAT_BITS-1:0]       cnt_q, cnt_d;
    logic [REG_ADDRS_BITS-1:0] rd_q, rd_d;
    logic                      overrun_q, overrun_d;
    logic                      busy_q, busy_d;
    logic                      wb_valid_q, wb_valid_d;
    logic [REG_ADDRS_BITS-1:0] wb_rd_q, wb_rd_d;

    logic [LAT_BITS-1:0]       w_lat_cnt;
    logic [2*NUM_SRC-1:0]      w_fwd;
    logic                      w_load_hit;
    logic                      w_mc_hit;

    // A latency of 0 behaves like 1: the slot is always busy at least one cycle
    assign w_lat_cnt = (bus.i_mc_latency == '0) ? '0 : bus.i_mc_latency - LAT_BITS'(1);

    // Slot next-state; busy/writeback outputs are computed one cycle ahead so
    // they come straight from flops
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        overrun_d  = overrun_q;
        busy_d     = 1'b0;
        wb_valid_d = 1'b0;
        wb_rd_d    = '0;
        case (state_q)
            MC_BUSY: begin
                // A second issue while occupied is dropped and flagged
                if (bus.i_mc_issue) begin
                    overrun_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d    = MC_DONE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                end else begin
                    cnt_d  = cnt_q - LAT_BITS'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept a new issue (back-to-back from DONE)
                if (bus.i_mc_issue) begin
                    state_d = MC_BUSY;
                    rd_d    = bus.i_mc_rd;
                    cnt_d   = w_lat_cnt;
                    busy_d  = 1'b1;
                end else begin
                    state_d = MC_IDLE;
                end
            end
        endcase
    end

    // Slot registers, cleared asynchronously so a reset mid-BUSY drops the result
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= MC_IDLE;
            cnt_q      <= '0;
            rd_q       <= '0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

    // One forward selector per ID/EX source operand
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        fwd_select #(
            .REG_ADDRS_BITS (REG_ADDRS_BITS)
        ) u_fwd_select (
            .i_ex_mem_we (bus.i_ex_mem_RegWrite),
            .i_ex_mem_rd (bus.i_ex_mem_rd),
            .i_mem_wb_we (bus.i_mem_wb_RegWrite),
            .i_mem_wb_rd (bus.i_mem_wb_rd),
            .i_mc_valid  (wb_valid_q),
            .i_mc_rd     (wb_rd_q),
            .i_src       (bus.i_id_ex_src[k*REG_ADDRS_BITS +: REG_ADDRS_BITS]),
            .o_sel       (w_fwd[2*k +: 2])
        );
    end

    // Hazard search over IF/ID sources: pending load result or pending multicycle result
    always_comb begin
        w_load_hit = 1'b0;
        w_mc_hit   = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.i_id_ex_MemRead && (bus.i_id_ex_rt != '0) &&
                (bus.i_id_ex_rt == bus.i_if_id_src[k*REG_ADDRS_BITS +: REG_ADDRS_BITS])) begin
                w_load_hit = 1'b1;
            end
            if ((state_q == MC_BUSY) && (rd_q != '0) &&
                (rd_q == bus.i_if_id_src[k*REG_ADDRS_BITS +: REG_ADDRS_BITS])) begin
                w_mc_hit = 1'b1;
            end
        end
    end

    assign bus.o_foward      = w_fwd;
    assign bus.o_stall       = w_load_hit || w_mc_hit ||
                               ((state_q == MC_BUSY) && bus.i_if_id_mc_req);
    assign bus.o_mc_busy     = busy_q;
    assign bus.o_mc_wb_valid = wb_valid_q;
    assign bus.o_mc_wb_rd    = wb_rd_q;
    assign bus.o_mc_overrun  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_forwarding_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_forwarding_scoreboard
//  Brief    : Directed bench for forwarding_scoreboard. Stimulus pushes the
//             expected values into queues; monitors pop and compare on the
//             falling clock edge (or on demand for the asynchronous reset).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_forwarding_scoreboard;

    localparam int RB = 5;
    localparam int NS = 2;
    localparam int LB = 3;

    localparam int S_FWD  = 0;
    localparam int S_STL  = 1;
    localparam int S_BSY  = 2;
    localparam int S_WBV  = 3;
    localparam int S_WBRD = 4;
    localparam int S_OVR  = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    forwarding_scoreboard_if #(.REG_ADDRS_BITS(RB), .NUM_SRC(NS), .LAT_BITS(LB)) bus ();

    forwarding_scoreboard #(
        .REG_ADDRS_BITS (RB),
        .NUM_SRC        (NS),
        .LAT_BITS       (LB)
    ) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    string       name_q[$];
    int          sel_q[$];
    logic [31:0] val_q[$];
    int          wb_q[$];
    event        ev_check;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endfunction

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_FWD:   return 32'(bus.o_foward);
            S_STL:   return 32'(bus.o_stall);
            S_BSY:   return 32'(bus.o_mc_busy);
            S_WBV:   return 32'(bus.o_mc_wb_valid);
            S_WBRD:  return 32'(bus.o_mc_wb_rd);
            default: return 32'(bus.o_mc_overrun);
        endcase
    endfunction

    task automatic expect_sig(input string nm, input int sel, input logic [31:0] v);
        name_q.push_back(nm);
        sel_q.push_back(sel);
        val_q.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_ex_mem_RegWrite = 1'b0;
        bus.i_mem_wb_RegWrite = 1'b0;
        bus.i_ex_mem_rd       = '0;
        bus.i_mem_wb_rd       = '0;
        bus.i_id_ex_src       = '0;
        bus.i_if_id_src       = '0;
        bus.i_id_ex_MemRead   = 1'b0;
        bus.i_id_ex_rt        = '0;
        bus.i_mc_issue        = 1'b0;
        bus.i_mc_rd           = '0;
        bus.i_mc_latency      = '0;
        bus.i_if_id_mc_req    = 1'b0;
    endtask

    // Expectation monitor: drains everything queued for this sample point
    initial begin
        forever begin
            @(negedge clk or ev_check);
            while (sel_q.size() > 0) begin
                chk(name_q.pop_front(), actual(sel_q.pop_front()), val_q.pop_front());
            end
        end
    end

    // Writeback monitor: every pulse must match the next scheduled result
    always @(negedge clk) begin
        if (bus.o_mc_wb_valid === 1'b1) begin
            if (wb_q.size() == 0) chk("wb_unexpected", 32'(bus.o_mc_wb_rd), 32'hdead);
            else                  chk("wb_rd_scoreboard", 32'(bus.o_mc_wb_rd), 32'(wb_q.pop_front()));
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        expect_sig("rst_fwd",  S_FWD,  0);
        expect_sig("rst_stl",  S_STL,  0);
        expect_sig("rst_bsy",  S_BSY,  0);
        expect_sig("rst_wbv",  S_WBV,  0);
        expect_sig("rst_wbrd", S_WBRD, 0);
        expect_sig("rst_ovr",  S_OVR,  0);
        tick();
        rst_n = 1'b1;

        // Forwarding priority
        tick();
        bus.i_ex_mem_RegWrite = 1'b1; bus.i_ex_mem_rd = 5'd5;
        bus.i_mem_wb_RegWrite = 1'b1; bus.i_mem_wb_rd = 5'd5;
        bus.i_id_ex_src = {5'd3, 5'd5};
        expect_sig("fwd_exmem_prio", S_FWD, 4'b0010);
        tick();
        bus.i_mem_wb_rd = 5'd3;
        expect_sig("fwd_exmem_memwb", S_FWD, 4'b0110);
        tick();
        bus.i_ex_mem_RegWrite = 1'b0; bus.i_mem_wb_rd = 5'd5;
        expect_sig("fwd_memwb_only", S_FWD, 4'b0001);
        tick();
        bus.i_ex_mem_RegWrite = 1'b1; bus.i_ex_mem_rd = 5'd0; bus.i_mem_wb_rd = 5'd0;
        bus.i_id_ex_src = '0;
        expect_sig("fwd_r0_never", S_FWD, 4'b0000);

        // Load-use stall
        tick();
        clear_inputs();
        bus.i_id_ex_MemRead = 1'b1; bus.i_id_ex_rt = 5'd7; bus.i_if_id_src = {5'd7, 5'd2};
        expect_sig("load_use_src1", S_STL, 1);
        tick();
        bus.i_if_id_src = {5'd4, 5'd2};
        expect_sig("load_no_match", S_STL, 0);
        tick();
        bus.i_id_ex_rt = 5'd0; bus.i_if_id_src = '0;
        expect_sig("load_rt0", S_STL, 0);

        // Multicycle latency 4, rd 9
        tick();
        clear_inputs();
        bus.i_mc_issue = 1'b1; bus.i_mc_rd = 5'd9; bus.i_mc_latency = 3'd4;
        bus.i_if_id_src = {5'd0, 5'd9};
        wb_q.push_back(9);
        expect_sig("mc4_issue_bsy", S_BSY, 0);
        expect_sig("mc4_issue_stl", S_STL, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.i_mc_issue = 1'b0;
            expect_sig("mc4_busy", S_BSY, 1);
            expect_sig("mc4_stall", S_STL, 1);
            expect_sig("mc4_wbv_lo", S_WBV, 0);
        end
        tick();
        bus.i_id_ex_src = {5'd0, 5'd9};
        expect_sig("mc4_done_bsy", S_BSY, 0);
        expect_sig("mc4_done_wbv", S_WBV, 1);
        expect_sig("mc4_done_wbrd", S_WBRD, 9);
        expect_sig("mc4_done_fwd", S_FWD, 4'b0011);
        expect_sig("mc4_done_stl", S_STL, 0);
        tick();
        expect_sig("mc4_after_wbv", S_WBV, 0);
        expect_sig("mc4_after_wbrd", S_WBRD, 0);
        expect_sig("mc4_after_fwd", S_FWD, 0);

        // Latency 0 then back-to-back latency 1 issued in DONE
        tick();
        clear_inputs();
        bus.i_mc_issue = 1'b1; bus.i_mc_rd = 5'd12; bus.i_mc_latency = 3'd0;
        wb_q.push_back(12);
        tick();
        bus.i_mc_issue = 1'b0;
        expect_sig("lat0_busy", S_BSY, 1);
        tick();
        expect_sig("lat0_done_wbv", S_WBV, 1);
        expect_sig("lat0_done_wbrd", S_WBRD, 12);
        bus.i_mc_issue = 1'b1; bus.i_mc_rd = 5'd10; bus.i_mc_latency = 3'd1;
        wb_q.push_back(10);
        tick();
        bus.i_mc_issue = 1'b0;
        expect_sig("b2b_busy", S_BSY, 1);
        expect_sig("b2b_wbv_lo", S_WBV, 0);
        tick();
        expect_sig("lat1_done_wbv", S_WBV, 1);
        expect_sig("lat1_done_wbrd", S_WBRD, 10);
        tick();
        expect_sig("lat1_idle_bsy", S_BSY, 0);
        expect_sig("lat1_idle_wbv", S_WBV, 0);

        // Overrun: issue while BUSY is dropped; multicycle request stalls
        tick();
        bus.i_mc_issue = 1'b1; bus.i_mc_rd = 5'd11; bus.i_mc_latency = 3'd3;
        wb_q.push_back(11);
        expect_sig("ovr_pre", S_OVR, 0);
        tick();
        bus.i_mc_rd = 5'd20; bus.i_mc_latency = 3'd1; bus.i_if_id_mc_req = 1'b1;
        expect_sig("ovr_busy", S_BSY, 1);
        expect_sig("ovr_mcreq_stall", S_STL, 1);
        expect_sig("ovr_not_yet", S_OVR, 0);
        tick();
        bus.i_mc_issue = 1'b0; bus.i_if_id_mc_req = 1'b0;
        expect_sig("ovr_set", S_OVR, 1);
        expect_sig("ovr_busy2", S_BSY, 1);
        expect_sig("ovr_nostall", S_STL, 0);
        tick();
        expect_sig("ovr_busy3", S_BSY, 1);
        tick();
        expect_sig("ovr_done_wbv", S_WBV, 1);
        expect_sig("ovr_done_wbrd", S_WBRD, 11);
        tick();
        expect_sig("ovr_sticky", S_OVR, 1);
        expect_sig("ovr_idle_bsy", S_BSY, 0);
        expect_sig("ovr_idle_wbv", S_WBV, 0);

        // Asynchronous reset mid-BUSY
        tick();
        bus.i_mc_issue = 1'b1; bus.i_mc_rd = 5'd13; bus.i_mc_latency = 3'd4;
        bus.i_if_id_src = {5'd0, 5'd13};
        tick();
        bus.i_mc_issue = 1'b0;
        expect_sig("ar_busy", S_BSY, 1);
        expect_sig("ar_stall", S_STL, 1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        expect_sig("ar_now_bsy", S_BSY, 0);
        expect_sig("ar_now_wbv", S_WBV, 0);
        expect_sig("ar_now_wbrd", S_WBRD, 0);
        expect_sig("ar_now_ovr", S_OVR, 0);
        expect_sig("ar_now_stl", S_STL, 0);
        -> ev_check;
        #1;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_sig("ar_post_wbv", S_WBV, 0);
            expect_sig("ar_post_bsy", S_BSY, 0);
        end

        tick();
        clear_inputs();
        @(negedge clk);
        #1;
        chk("wb_drain", 32'(wb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
